adder_share_arbiter: RTL

- Time-shares one WIDTH-bit adder between two independent requesters.
- Each requester uses a valid/ready interface to present an operand pair.
- Round-robin arbitration picks one winner per cycle. The registered sum is returned with a requester ID over a valid/ready result port that supports backpressure.
- Sits between the user-project pin logic and the shared adder datapath.

---
 rtl/adder_share_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Shares one WIDTH-bit adder between two valid/ready requesters with round-robin
// arbitration and a registered, backpressured result port. Optional: ADDER_SHARE_SAT_EN.
module adder_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count
);

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_carry_q, res_carry_d;
  logic             res_id_q, res_id_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             last_grant_q, last_grant_d;

  logic             slot_free;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum_result;

  // Round-robin: on contention the requester that did not win last goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   begin grant_valid = 1'b1; grant_id = 1'b0;          end
      2'b10:   begin grant_valid = 1'b1; grant_id = 1'b1;          end
      2'b11:   begin grant_valid = 1'b1; grant_id = ~last_grant_q; end
      default: begin grant_valid = 1'b0; grant_id = 1'b0;          end
    endcase
  end

  assign slot_free  = ~res_valid_q | res_ready;
  // rst_n gates the readies so nothing handshakes while the block is held in reset.
  assign accept     = grant_valid & slot_free & rst_n;
  assign consume    = res_valid_q & res_ready;
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept &  grant_id;

  // Single shared adder fed through the operand mux.
  assign op_a     = grant_id ? req1_a : req0_a;
  assign op_b     = grant_id ? req1_b : req0_b;
  assign add_full = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_SHARE_SAT_EN
  assign sum_result = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
  assign sum_result = add_full[WIDTH-1:0];
`endif

  // NOTE: every _d is defaulted to its _q first so no path leaves a latch.
  always_comb begin
    res_valid_d  = res_valid_q;
    res_sum_d    = res_sum_q;
    res_carry_d  = res_carry_q;
    res_id_d     = res_id_q;
    op_count_d   = op_count_q;
    last_grant_d = last_grant_q;

    if (consume) begin
      op_count_d  = op_count_q + 1'b1;
      res_valid_d = 1'b0;
    end
    if (accept) begin
      res_sum_d    = sum_result;
      res_carry_d  = add_full[WIDTH];
      res_id_d     = grant_id;
      res_valid_d  = 1'b1;
      last_grant_d = grant_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q  <= 1'b0;
      res_sum_q    <= '0;
      res_carry_q  <= 1'b0;
      res_id_q     <= 1'b0;
      op_count_q   <= '0;
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_sum_q    <= res_sum_d;
      res_carry_q  <= res_carry_d;
      res_id_q     <= res_id_d;
      op_count_q   <= op_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule
